// File: rtl/beam_scan_ctrl_pkg.sv
// Shared types for the beam scan sequencer: FSM encoding, index struct, default widths.
// The default widths match top_bf's focal coordinate and output widths.
package beam_scan_ctrl_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int OUT_W_DEF   = 18;
  localparam int IDX_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] x_idx;
    logic [IDX_W-1:0] z_idx;
  } scan_idx_t;

  // Index of the last element of an n-long axis.
  function automatic logic [IDX_W-1:0] axis_last(input int n);
    return IDX_W'(n - 1);
  endfunction

endpackage

// File: rtl/beam_coord_gen.sv
// Scan-grid walker: z (depth) inner, x (scanline) outer, with accumulating focal
// coordinates that wrap modulo 2^COORD_W.
module beam_coord_gen
  import beam_scan_ctrl_pkg::*;
#(
  parameter int                 COORD_W = COORD_W_DEF,
  parameter int                 NX      = 64,
  parameter int                 NZ      = 256,
  parameter logic [COORD_W-1:0] X_START = '0,
  parameter logic [COORD_W-1:0] X_STEP  = COORD_W'(1),
  parameter logic [COORD_W-1:0] Z_START = '0,
  parameter logic [COORD_W-1:0] Z_STEP  = COORD_W'(1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  output scan_idx_t          idx,
  output logic [COORD_W-1:0] x_f,
  output logic [COORD_W-1:0] z_f,
  output logic               last
);

  localparam logic [IDX_W-1:0] X_LAST = axis_last(NX);
  localparam logic [IDX_W-1:0] Z_LAST = axis_last(NZ);

  logic z_last;

  assign z_last = (idx.z_idx == Z_LAST);
  assign last   = z_last && (idx.x_idx == X_LAST);

  // Stepping past the final point rewinds to the origin so the next frame starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      x_f <= X_START;
      z_f <= Z_START;
    end else if (clear || (step && last)) begin
      idx <= '0;
      x_f <= X_START;
      z_f <= Z_START;
    end else if (step) begin
      if (z_last) begin
        idx.z_idx <= '0;
        z_f       <= Z_START;
        idx.x_idx <= idx.x_idx + IDX_W'(1);
        x_f       <= x_f + X_STEP;
      end else begin
        idx.z_idx <= idx.z_idx + IDX_W'(1);
        z_f       <= z_f + Z_STEP;
      end
    end
  end

endmodule

// File: rtl/beam_scan_ctrl.sv
// Frame-level sequencer for top_bf: issues one beamform per focal point, waits for
// valid with a timeout, and streams each captured sample out on a valid/ready port.
module beam_scan_ctrl
  import beam_scan_ctrl_pkg::*;
#(
  parameter int                 COORD_W = COORD_W_DEF,
  parameter int                 OUT_W   = OUT_W_DEF,
  parameter int                 NX      = 64,
  parameter int                 NZ      = 256,
  parameter logic [COORD_W-1:0] X_START = '0,
  parameter logic [COORD_W-1:0] X_STEP  = COORD_W'(1),
  parameter logic [COORD_W-1:0] Z_START = '0,
  parameter logic [COORD_W-1:0] Z_STEP  = COORD_W'(1),
  parameter int                 TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  output logic               bf_start,
  output logic [COORD_W-1:0] bf_x_f,
  output logic [COORD_W-1:0] bf_z_f,
  input  logic               bf_valid,
  input  logic [OUT_W-1:0]   bf_out,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [OUT_W-1:0]   pix_data,
  output logic [15:0]        pix_x_idx,
  output logic [15:0]        pix_z_idx,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err
);

  localparam int               TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  scan_state_e     state, state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            coord_clear, coord_step, coord_last, to_hit;
  scan_idx_t       idx;

  beam_coord_gen #(
    .COORD_W (COORD_W),
    .NX      (NX),
    .NZ      (NZ),
    .X_START (X_START),
    .X_STEP  (X_STEP),
    .Z_START (Z_START),
    .Z_STEP  (Z_STEP)
  ) u_coord (
    .clk   (clk),
    .reset (reset),
    .clear (coord_clear),
    .step  (coord_step),
    .idx   (idx),
    .x_f   (bf_x_f),
    .z_f   (bf_z_f),
    .last  (coord_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    coord_clear = 1'b0;
    coord_step  = 1'b0;
    to_hit      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt   = ST_ISSUE;
          coord_clear = 1'b1;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bf_valid) begin
          state_nxt = ST_EMIT;
        end else if (wait_cnt == TO_LAST) begin
          state_nxt = ST_IDLE;
          to_hit    = 1'b1;
        end
      end
      ST_EMIT: begin
        if (pix_ready) begin
          coord_step = 1'b1;
          state_nxt  = coord_last ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter rearms every ISSUE, so the timeout bounds each point, not the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      pix_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_ISSUE)     wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + TO_W'(1);
      if (state == ST_WAIT && bf_valid) pix_data <= bf_out;
      if (to_hit)           timeout_err <= 1'b1;
      else if (coord_clear) timeout_err <= 1'b0;
    end
  end

  assign bf_start   = (state == ST_ISSUE);
  assign pix_valid  = (state == ST_EMIT);
  assign frame_done = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign pix_x_idx  = idx.x_idx;
  assign pix_z_idx  = idx.z_idx;

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Bench for beam_scan_ctrl: two instances (normal stepping and wrapping x step) driven
// by a latency-3 top_bf model, checked against a grid-walk reference and a vector table.
module tb_beam_scan_ctrl;

  localparam int CW = 16, OW = 18, NX = 2, NZ = 3, TO = 8, NPIX = NX * NZ;

  // Per-instance scan parameters, used by the reference model.
  int XS [2] = '{10, 0};
  int XST[2] = '{4, 65535};
  int ZS [2] = '{100, 100};
  int ZST[2] = '{2, 2};

  logic          clk = 1'b0;
  logic          reset;
  logic          fs [2], pr [2], bfv [2], bfs [2], pv [2], bsy [2], fdn [2], terr [2];
  logic [OW-1:0] bfo [2], pd [2];
  logic [CW-1:0] bxf [2], bzf [2];
  logic [15:0]   pxi [2], pzi [2];

  always #5 clk = ~clk;

  beam_scan_ctrl #(
    .COORD_W(CW), .OUT_W(OW), .NX(NX), .NZ(NZ), .X_START(16'd10), .X_STEP(16'd4),
    .Z_START(16'd100), .Z_STEP(16'd2), .TIMEOUT(TO)
  ) u_dut0 (
    .clk(clk), .reset(reset), .frame_start(fs[0]), .bf_start(bfs[0]), .bf_x_f(bxf[0]),
    .bf_z_f(bzf[0]), .bf_valid(bfv[0]), .bf_out(bfo[0]), .pix_valid(pv[0]),
    .pix_ready(pr[0]), .pix_data(pd[0]), .pix_x_idx(pxi[0]), .pix_z_idx(pzi[0]),
    .busy(bsy[0]), .frame_done(fdn[0]), .timeout_err(terr[0])
  );

  beam_scan_ctrl #(
    .COORD_W(CW), .OUT_W(OW), .NX(NX), .NZ(NZ), .X_START(16'd0), .X_STEP(16'hFFFF),
    .Z_START(16'd100), .Z_STEP(16'd2), .TIMEOUT(TO)
  ) u_dut1 (
    .clk(clk), .reset(reset), .frame_start(fs[1]), .bf_start(bfs[1]), .bf_x_f(bxf[1]),
    .bf_z_f(bzf[1]), .bf_valid(bfv[1]), .bf_out(bfo[1]), .pix_valid(pv[1]),
    .pix_ready(pr[1]), .pix_data(pd[1]), .pix_x_idx(pxi[1]), .pix_z_idx(pzi[1]),
    .busy(bsy[1]), .frame_done(fdn[1]), .timeout_err(terr[1])
  );

  // top_bf model: one valid pulse 3 cycles after bf_start, data = x_f + z_f.
  logic [2:0]    lat [2];
  logic [CW-1:0] mx [2], mz [2];
  logic          bf_en [2], spur [2];

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        lat[i] <= '0; mx[i] <= '0; mz[i] <= '0;
      end else begin
        lat[i] <= {lat[i][1:0], bfs[i] & bf_en[i]};
        if (bfs[i]) begin mx[i] <= bxf[i]; mz[i] <= bzf[i]; end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bfv[i] = lat[i][2] | spur[i];
      bfo[i] = spur[i] ? 18'h2ABCD : OW'({1'b0, mx[i]} + {1'b0, mz[i]});
    end
  end

  // Monitor: accepted pixels, issued points and frame_done pulses, append-only.
  typedef struct { int d; int xi; int zi; int data; int xf; int zf; } rec_t;
  rec_t acc_q[$], iss_q[$];
  int   done_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rec_t r;
      r.d = i; r.xi = int'(pxi[i]); r.zi = int'(pzi[i]); r.data = int'(pd[i]);
      r.xf = int'(bxf[i]); r.zf = int'(bzf[i]);
      if (pv[i] && pr[i]) acc_q.push_back(r);
      if (bfs[i]) iss_q.push_back(r);
      if (fdn[i]) done_cnt[i]++;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference grid walk: point k is scanline k/NZ, depth k%NZ.
  function automatic int ref_x(input int d, input int k);
    return (XS[d] + (k / NZ) * XST[d]) % 65536;
  endfunction
  function automatic int ref_z(input int d, input int k);
    return (ZS[d] + (k % NZ) * ZST[d]) % 65536;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_fs(input int d);
    fs[d] = 1'b1; tick(); fs[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input int budget, output int cyc);
    cyc = 0;
    while (bsy[d] && cyc < budget) begin tick(); cyc++; end
    chk("idle_reached", bsy[d], 1'b0);
  endtask

  task automatic check_frame(input int d, input int ba, input int bi, input int bd, input string tag);
    int na, ni;
    na = acc_q.size() - ba;
    ni = iss_q.size() - bi;
    chk({tag, "_npix"}, na, NPIX);
    chk({tag, "_nissue"}, ni, NPIX);
    chk({tag, "_ndone"}, done_cnt[d] - bd, 1);
    for (int k = 0; k < NPIX && k < na; k++) begin
      chk({tag, "_xi"}, acc_q[ba + k].xi, k / NZ);
      chk({tag, "_zi"}, acc_q[ba + k].zi, k % NZ);
      chk({tag, "_data"}, acc_q[ba + k].data, ref_x(d, k) + ref_z(d, k));
    end
    for (int k = 0; k < NPIX && k < ni; k++) begin
      chk({tag, "_xf"}, iss_q[bi + k].xf, ref_x(d, k));
      chk({tag, "_zf"}, iss_q[bi + k].zf, ref_z(d, k));
    end
  endtask

  typedef struct { int stall; int xi; int zi; int xf; int zf; int data; } vec_t;
  vec_t tbl[NPIX];

  initial begin
    int ba, bi, bd, cyc, n, nb;

    tbl = '{'{0, 0, 0, 10, 100, 110}, '{1, 0, 1, 10, 102, 112}, '{0, 0, 2, 10, 104, 114},
            '{3, 1, 0, 14, 100, 114}, '{0, 1, 1, 14, 102, 116}, '{2, 1, 2, 14, 104, 118}};
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fs[i] = 1'b0; pr[i] = 1'b0; bf_en[i] = 1'b1; spur[i] = 1'b0;
    end
    tick(); tick();

    // Reset state of both instances.
    for (int i = 0; i < 2; i++) begin
      chk("rst_outs", {bfs[i], pv[i], bsy[i], fdn[i], terr[i]}, 0);
      chk("rst_data", pd[i], 0);
      chk("rst_idx", {pxi[i], pzi[i]}, 0);
      chk("rst_xf", bxf[i], XS[i]);
      chk("rst_zf", bzf[i], ZS[i]);
    end
    reset = 1'b0;
    tick();

    // Table-driven frame with per-pixel stalls and exact done timing.
    ba = acc_q.size(); bd = done_cnt[0];
    pulse_fs(0);
    for (int i = 0; i < NPIX; i++) begin
      n = 0;
      while (!pv[0] && n < 50) begin tick(); n++; end
      chk("t1_pv", pv[0], 1'b1);
      repeat (tbl[i].stall) tick();
      chk("t1_pv_held", pv[0], 1'b1);
      chk("t1_xi", pxi[0], tbl[i].xi);
      chk("t1_zi", pzi[0], tbl[i].zi);
      chk("t1_xf", bxf[0], tbl[i].xf);
      chk("t1_zf", bzf[0], tbl[i].zf);
      chk("t1_data", pd[0], tbl[i].data);
      pr[0] = 1'b1; tick(); pr[0] = 1'b0;
    end
    chk("t1_done_pulse", fdn[0], 1'b1);
    tick();
    chk("t1_busy_off", bsy[0], 1'b0);
    chk("t1_done_once", done_cnt[0] - bd, 1);
    chk("t1_accepted", acc_q.size() - ba, NPIX);

    // Backpressure on the second pixel.
    ba = acc_q.size(); bi = iss_q.size(); bd = done_cnt[0];
    pr[0] = 1'b1;
    pulse_fs(0);
    n = 0;
    while (!(pv[0] && pzi[0] == 16'd1) && n < 60) begin tick(); n++; end
    pr[0] = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t2_pv", pv[0], 1'b1);
      chk("t2_data", pd[0], 112);
      chk("t2_idx", {pxi[0], pzi[0]}, {16'd0, 16'd1});
      chk("t2_coord", {bxf[0], bzf[0]}, {16'd10, 16'd102});
      chk("t2_no_start", bfs[0], 1'b0);
    end
    pr[0] = 1'b1;
    wait_idle(0, 200, cyc);
    check_frame(0, ba, bi, bd, "t2");

    // Timeout: model silent, then recovery frame.
    bd = done_cnt[0];
    bf_en[0] = 1'b0;
    pulse_fs(0);
    wait_idle(0, 50, cyc);
    chk("t3_cycles", cyc, 1 + TO);
    chk("t3_terr", terr[0], 1'b1);
    chk("t3_no_done", done_cnt[0] - bd, 0);
    tick(); tick();
    chk("t3_terr_sticky", terr[0], 1'b1);
    bf_en[0] = 1'b1;
    ba = acc_q.size(); bi = iss_q.size(); bd = done_cnt[0];
    pulse_fs(0);
    chk("t3_terr_clear", terr[0], 1'b0);
    wait_idle(0, 200, cyc);
    check_frame(0, ba, bi, bd, "t3");

    // frame_start mid-frame and during DONE is ignored; back-to-back timing.
    ba = acc_q.size(); bi = iss_q.size(); bd = done_cnt[0];
    pr[0] = 1'b1;
    pulse_fs(0);
    cyc = 0;
    while (bsy[0] && cyc < 100) begin
      fs[0] = (cyc == 7) || fdn[0];
      tick(); cyc++;
    end
    fs[0] = 1'b0;
    chk("t4_cycles", cyc, NPIX * 5 + 1);
    tick(); tick();
    chk("t4_stays_idle", bsy[0], 1'b0);
    check_frame(0, ba, bi, bd, "t4");

    // Asynchronous reset during WAIT of the fourth point.
    bd = done_cnt[0];
    pulse_fs(0);
    nb = 0; n = 0;
    while (n < 100) begin
      if (bfs[0]) nb++;
      if (nb == 4) break;
      tick(); n++;
    end
    chk("t5_fourth_issue", {bxf[0], bzf[0]}, {16'd14, 16'd100});
    tick();
    reset = 1'b1;
    #1;
    chk("t5_outs", {bfs[0], pv[0], bsy[0], fdn[0], terr[0]}, 0);
    chk("t5_data", pd[0], 0);
    chk("t5_idx", {pxi[0], pzi[0]}, 0);
    chk("t5_coord", {bxf[0], bzf[0]}, {16'd10, 16'd100});
    tick();
    reset = 1'b0;
    tick();
    chk("t5_no_done", done_cnt[0] - bd, 0);
    ba = acc_q.size(); bi = iss_q.size(); bd = done_cnt[0];
    pulse_fs(0);
    wait_idle(0, 200, cyc);
    check_frame(0, ba, bi, bd, "t5");

    // Wrapping x step; spurious bf_valid during EMIT.
    ba = acc_q.size(); bi = iss_q.size(); bd = done_cnt[1];
    pr[1] = 1'b1;
    pulse_fs(1);
    wait_idle(1, 200, cyc);
    check_frame(1, ba, bi, bd, "t6");
    if (iss_q.size() - bi >= 4) chk("t6_wrap_xf", iss_q[bi + 3].xf, 16'hFFFF);
    else chk("t6_wrap_issues", iss_q.size() - bi, NPIX);
    pr[1] = 1'b0;
    pulse_fs(1);
    n = 0;
    while (!pv[1] && n < 50) begin tick(); n++; end
    spur[1] = 1'b1; tick(); spur[1] = 1'b0; tick();
    chk("t6_spur_pv", pv[1], 1'b1);
    chk("t6_spur_data", pd[1], 100);
    pr[1] = 1'b1;
    wait_idle(1, 200, cyc);

    // Randomised backpressure on both instances.
    for (int r = 0; r < 4; r++) begin
      int d;
      d = r % 2;
      ba = acc_q.size(); bi = iss_q.size(); bd = done_cnt[d];
      pr[d] = 1'($urandom_range(0, 1));
      pulse_fs(d);
      n = 0;
      while (bsy[d] && n < 500) begin
        pr[d] = 1'($urandom_range(0, 1));
        tick(); n++;
      end
      chk("rnd_idle", bsy[d], 1'b0);
      check_frame(d, ba, bi, bd, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
